// File: rtl/zle_share_arb.sv
// Time-shares one zero run-length encoder among N requester stream pairs, switching only at encoder idle.
// Optional build macro ZLE_SHARE_ARB_FIXED_PRIO_EN selects fixed-priority arbitration instead of round-robin.
module zle_share_arb #(
    parameter int N       = 2,
    parameter int SELW    = 1,
    parameter int QUANTUM = 16,
    parameter int STARVE  = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    in_v,
    output logic [N-1:0]    in_b,
    output logic [N-1:0]    out_v,
    input  logic [N-1:0]    out_b,
    output logic            enc_i_v,
    input  logic            enc_i_b,
    input  logic            enc_o_v,
    output logic            enc_o_b,
    input  logic            enc_idle,
    output logic [SELW-1:0] sel_src,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam logic [7:0]      QUANT_C  = 8'(QUANTUM);
    localparam logic [7:0]      STARVE_C = 8'(STARVE);
    localparam logic [SELW-1:0] LAST_RST = SELW'(N - 1);

    state_t          state_q, state_d;
    logic [SELW-1:0] grant_q, grant_d;
    logic [SELW-1:0] last_q, last_d;
    logic [7:0]      tok_cnt_q, tok_cnt_d;
    logic [7:0]      starve_cnt_q, starve_cnt_d;
    logic            yield_q, yield_d;
    logic            busy_q, busy_d;
    logic            gate_s;
    logic            xfer_s;

    function automatic logic [SELW-1:0] pick_req(input logic [N-1:0] req,
                                                 input logic [SELW-1:0] last);
        logic [SELW-1:0] pick;
        logic [SELW-1:0] idx_sel;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
`ifdef ZLE_SHARE_ARB_FIXED_PRIO_EN
        for (int k = N - 1; k >= 0; k--) begin
            idx_sel = SELW'(k);
            if (req[idx_sel]) begin
                pick = idx_sel;
            end
        end
`else
        // Search starts just after the previous owner so every requester gets a turn.
        for (int k = 1; k <= N; k++) begin
            idx     = (int'(last) + k) % N;
            idx_sel = SELW'(idx);
            if (!found && req[idx_sel]) begin
                pick  = idx_sel;
                found = 1'b1;
            end
        end
`endif
        return pick;
    endfunction

    // State and grant bookkeeping registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_q       <= LAST_RST;
            tok_cnt_q    <= 8'd0;
            starve_cnt_q <= 8'd0;
            yield_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            tok_cnt_q    <= tok_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            yield_q      <= yield_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic and stream routing to and from the shared encoder.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        tok_cnt_d    = tok_cnt_q;
        starve_cnt_d = starve_cnt_q;
        yield_d      = yield_q;
        in_b         = '1;
        out_v        = '0;
        enc_i_v      = 1'b0;
        enc_o_b      = 1'b1;
        gate_s       = 1'b0;
        xfer_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|in_v) begin
                    grant_d      = pick_req(in_v, last_q);
                    tok_cnt_d    = 8'd0;
                    starve_cnt_d = 8'd0;
                    yield_d      = 1'b0;
                    state_d      = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Once a yield is pending, input is cut only at a token boundary.
                gate_s         = yield_q & enc_idle;
                enc_i_v        = in_v[grant_q] & ~gate_s;
                in_b[grant_q]  = enc_i_b | gate_s;
                out_v[grant_q] = enc_o_v;
                enc_o_b        = out_b[grant_q];
                xfer_s         = in_v[grant_q] & ~gate_s & ~enc_i_b;
                if (xfer_s && (tok_cnt_q != QUANT_C)) begin
                    tok_cnt_d = tok_cnt_q + 8'd1;
                end else begin
                    tok_cnt_d = tok_cnt_q;
                end
                if (!in_v[grant_q] && enc_idle) begin
                    if (starve_cnt_q != STARVE_C) begin
                        starve_cnt_d = starve_cnt_q + 8'd1;
                    end else begin
                        starve_cnt_d = starve_cnt_q;
                    end
                end else begin
                    starve_cnt_d = 8'd0;
                end
                yield_d = yield_q | (tok_cnt_d == QUANT_C) | (starve_cnt_d == STARVE_C);
                if (gate_s) begin
                    state_d = ST_SWITCH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SWITCH: begin
                out_v[grant_q] = enc_o_v;
                enc_o_b        = out_b[grant_q];
                last_d         = grant_q;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                grant_d      = '0;
                last_d       = LAST_RST;
                tok_cnt_d    = 8'd0;
                starve_cnt_d = 8'd0;
                yield_d      = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign sel_src = grant_q;
    assign busy    = busy_q;

endmodule
